// File: rtl/mmio_console_if.sv
// CPU data-port bus and console byte-sink handshake
// for the memory-mapped console responder.
interface mmio_console_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic        hit;
  logic [31:0] rdata;
  logic        stall;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halted;
  logic [7:0]  exit_code;

  modport master (
    output addr, wdata, we, re, tx_ready,
    input  hit, rdata, stall, tx_data,
    input  tx_valid, halted, exit_code
  );

  modport slave (
    input  addr, wdata, we, re, tx_ready,
    output hit, rdata, stall, tx_data,
    output tx_valid, halted, exit_code
  );
endinterface

// File: rtl/mmio_console.sv
// Memory-stage console: byte FIFO to a valid/ready
// sink, status loads, sticky exit-code latch.
module mmio_console #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input logic           clk,
  input logic           rst_n,
  mmio_console_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          halted_q, halted_d;
  logic [7:0]    exit_q, exit_d;

  logic       hit;
  logic [1:0] sel;
  logic       sel_data, sel_status, sel_exit;
  logic       empty, full;
  logic       push, pop;
  logic [31:0] rdata;
  logic [31:0] status;
  logic       unused_bits;

  assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

  assign hit        = bus.addr[31:4] == BASE_ADDR[31:4];
  assign sel        = bus.addr[3:2];
  assign sel_data   = hit && sel == 2'd0;
  assign sel_status = hit && sel == 2'd1;
  assign sel_exit   = hit && sel == 2'd2;

  assign empty = count_q == '0;
  assign full  = count_q == FULL_CNT;

  // Stall depends only on registered state, never on tx_ready.
  assign push = bus.we && sel_data && !full && !halted_q;
  assign pop  = !empty && bus.tx_ready;

  assign status = {15'b0, halted_q, 8'(count_q),
                   6'b0, full, empty};

  assign bus.hit       = hit;
  assign bus.rdata     = rdata;
  assign bus.stall     = bus.we && sel_data && full && !halted_q;
  assign bus.tx_valid  = !empty;
  assign bus.tx_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.halted    = halted_q;
  assign bus.exit_code = exit_q;

  // Load data decode; reserved and DATA read as zero.
  always_comb begin
    rdata = '0;
    if (bus.re) begin
      unique case (1'b1)
        sel_status: rdata = status;
        sel_exit:   rdata = {24'b0, exit_q};
        default:    rdata = '0;
      endcase
    end
  end

  // Next-state for pointers, occupancy and exit latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    halted_d = halted_q;
    exit_d   = exit_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (bus.we && sel_exit) begin
      halted_d = 1'b1;
      exit_d   = bus.wdata[7:0];
    end
  end

  // Control state; reset drops queued bytes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      exit_q   <= 8'h00;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
      exit_q   <= exit_d;
    end
  end

  // Byte storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wdata[7:0];
  end

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: ordering, stall,
// halt and reset behaviour with hand-computed values.
module tb_mmio_console;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] rx_q [$];
  logic [31:0] d;

  always #5 clk = ~clk;

  mmio_console_if bus ();

  mmio_console #(
    .DEPTH(8),
    .BASE_ADDR(BASE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Record each byte the sink accepts, in order.
  always @(negedge clk) begin
    if (bus.tx_valid && bus.tx_ready)
      rx_q.push_back(bus.tx_data);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               tag, obs, exp);
    end
  endtask

  task automatic st(input logic [31:0] a,
                    input logic [31:0] v);
    bus.addr  = a;
    bus.wdata = v;
    bus.we    = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] v);
    bus.addr = a;
    bus.re   = 1'b1;
    #1;
    v = bus.rdata;
    bus.re = 1'b0;
  endtask

  task automatic drain();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 40 && bus.tx_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_done", bus.tx_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.we       = 1'b0;
    bus.re       = 1'b0;
    bus.tx_ready = 1'b0;
    #12;
    chk("rst_valid", bus.tx_valid, 1'b0);
    chk("rst_data", bus.tx_data, 8'h00);
    chk("rst_halt", bus.halted, 1'b0);
    chk("rst_exit", bus.exit_code, 8'h00);
    chk("rst_stall", bus.stall, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(BASE + 4, d);
    chk("rst_status", d, 32'h0000_0001);

    // Two stores, sink always ready.
    bus.tx_ready = 1'b1;
    st(BASE, 32'h48);
    chk("hi_v0", bus.tx_valid, 1'b1);
    chk("hi_d0", bus.tx_data, 8'h48);
    st(BASE, 32'h69);
    chk("hi_d1", bus.tx_data, 8'h69);
    @(posedge clk);
    #1;
    chk("hi_empty", bus.tx_valid, 1'b0);
    chk("hi_cnt", rx_q.size(), 2);
    rx_q.delete();

    // Fill to full, then stall on the ninth.
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) st(BASE, i);
    rd(BASE + 4, d);
    chk("full_status", d, 32'h0000_0802);
    bus.addr  = BASE;
    bus.wdata = 32'h09;
    bus.we    = 1'b1;
    #1;
    chk("stall_on", bus.stall, 1'b1);
    @(posedge clk);
    #1;
    chk("stall_hold", bus.stall, 1'b1);
    bus.tx_ready = 1'b1;
    #1;
    chk("stall_rdy", bus.stall, 1'b1);
    @(posedge clk);
    #1;
    chk("stall_off", bus.stall, 1'b0);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    drain();
    chk("ord_n", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      chk($sformatf("ord_%0d", i), rx_q[i], i + 1);
    rx_q.delete();

    // Push and pop together at count 3.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) st(BASE, 8'hA0 + i);
    bus.tx_ready = 1'b1;
    for (int i = 3; i < 8; i++) st(BASE, 8'hA0 + i);
    bus.tx_ready = 1'b0;
    rd(BASE + 4, d);
    chk("pp_status", d, 32'h0000_0300);
    drain();
    chk("pp_n", rx_q.size(), 8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      chk($sformatf("pp_%0d", i), rx_q[i], 8'hA0 + i);
    rx_q.delete();

    // Halt with a full FIFO; DATA store dropped.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) st(BASE, 8'hB0 + i);
    st(BASE + 8, 32'h2A);
    chk("halt_on", bus.halted, 1'b1);
    chk("halt_code", bus.exit_code, 8'h2A);
    rd(BASE + 4, d);
    chk("halt_status", d, 32'h0001_0802);
    rd(BASE + 8, d);
    chk("exit_rd", d, 32'h0000_002A);
    bus.addr  = BASE;
    bus.wdata = 32'h33;
    bus.we    = 1'b1;
    #1;
    chk("halt_nostall", bus.stall, 1'b0);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    rd(BASE + 4, d);
    chk("halt_keep", d, 32'h0001_0802);
    drain();
    chk("halt_n", rx_q.size(), 8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      chk($sformatf("halt_%0d", i), rx_q[i], 8'hB0 + i);
    rx_q.delete();
    st(BASE + 8, 32'h55);
    chk("exit_over", bus.exit_code, 8'h55);
    chk("halt_stay", bus.halted, 1'b1);

    // Reset clears halt; then reset mid-drain.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_halt2", bus.halted, 1'b0);
    chk("rst_exit2", bus.exit_code, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bus.tx_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) st(BASE, 8'hC0 + i);
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b0;
    rd(BASE + 4, d);
    chk("mid_status", d, 32'h0000_0500);
    chk("mid_head", bus.tx_data, 8'hC1);
    bus.tx_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", bus.tx_valid, 1'b0);
    chk("mid_data", bus.tx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bus.tx_ready = 1'b0;
    @(posedge clk);
    #1;
    rd(BASE + 4, d);
    chk("post_status", d, 32'h0000_0001);
    chk("post_halt", bus.halted, 1'b0);
    rx_q.delete();

    // Reserved and out-of-window accesses.
    rd(BASE + 12, d);
    chk("rsv_rd", d, 32'h0);
    bus.addr = BASE + 16;
    #1;
    chk("miss_hit", bus.hit, 1'b0);
    rd(BASE + 16, d);
    chk("miss_rd", d, 32'h0);
    rd(BASE, d);
    chk("data_rd", d, 32'h0);
    bus.addr = BASE + 4;
    #1;
    chk("no_re", bus.rdata, 32'h0);
    st(BASE + 12, 32'h77);
    st(BASE + 16, 32'h77);
    rd(BASE + 4, d);
    chk("rsv_status", d, 32'h0000_0001);
    chk("rsv_exit", bus.exit_code, 8'h00);

    // Store and load strobes together.
    bus.addr  = BASE;
    bus.wdata = 32'h5A;
    bus.we    = 1'b1;
    bus.re    = 1'b1;
    #1;
    chk("both_rd", bus.rdata, 32'h0);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    bus.re = 1'b0;
    chk("both_push", bus.tx_data, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
